register_dump_reader: RTL



---
 rtl/debug_pkg.sv | 27 ++
 rtl/register_dump_reader_if.sv | 25 ++
 rtl/word_serializer.sv | 84 ++++++++
 rtl/register_dump_reader.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared debug-path constants and the dump reader state encoding.
// The ST_CSUM state exists only when REG_DUMP_CHECKSUM_EN is defined.
package debug_pkg;

    localparam int NUM_REGS_DEF       = 32;
    localparam int ADDR_W_DEF         = 5;
    localparam int DATA_W_DEF         = 32;
    localparam int BYTE_W_DEF         = 8;
    localparam int BYTES_PER_WORD     = DATA_W_DEF / BYTE_W_DEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SEND,
        ST_WAIT,
        ST_NEXT,
`ifdef REG_DUMP_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_FINISH
    } dump_state_t;

    function automatic int idx_width(input int bytes_per_word);
        return (bytes_per_word > 1) ? $clog2(bytes_per_word) : 1;
    endfunction

endpackage

// File: rtl/register_dump_reader_if.sv
// Bundle of bank read port, byte transmitter handshake and dump control.
interface register_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int BYTE_W = 8
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] dir_read;
    logic [DATA_W-1:0] read_data;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_start;
    logic              tx_done;

    modport master (
        input  start, read_data, tx_done,
        output busy, done, dir_read, tx_data, tx_start
    );

    modport slave (
        output start, read_data, tx_done,
        input  busy, done, dir_read, tx_data, tx_start
    );
endinterface

// File: rtl/word_serializer.sv
// Holds the captured register word and emits it MSB-first, one byte at a time.
// With REG_DUMP_CHECKSUM_EN it also keeps the running XOR of every emitted byte.
module word_serializer
    import debug_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_capture,
    input  logic              i_next_byte,
    input  logic [DATA_W-1:0] i_read_data,
`ifdef REG_DUMP_CHECKSUM_EN
    input  logic              i_clear,
    input  logic              i_load_csum,
`endif
    output logic [BYTE_W-1:0] o_tx_data,
    output logic              o_last_byte
);
    localparam int BPW   = DATA_W / BYTE_W;
    localparam int IDX_W = idx_width(BPW);

    logic [DATA_W-1:0] r_word;
    logic [IDX_W-1:0]  r_idx;
    logic [BYTE_W-1:0] r_tx_data;

    logic [IDX_W-1:0]  w_next_idx;
    logic [BYTE_W-1:0] w_first_byte;
    logic [BYTE_W-1:0] w_next_byte;

    assign w_next_idx   = r_idx + 1'b1;
    assign w_first_byte = i_read_data[DATA_W-1 -: BYTE_W];
    // Byte selection is a right shift so byte 0 of the dump is the word's top byte.
    assign w_next_byte  = BYTE_W'(r_word >> (BYTE_W * (BPW - 1 - int'(w_next_idx))));
    assign o_last_byte  = (r_idx == IDX_W'(BPW - 1));
    assign o_tx_data    = r_tx_data;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [BYTE_W-1:0] r_csum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word    <= '0;
            r_idx     <= '0;
            r_tx_data <= '0;
            r_csum    <= '0;
        end else begin
            if (i_clear) begin
                r_csum <= '0;
            end else if (i_capture) begin
                r_word    <= i_read_data;
                r_idx     <= '0;
                r_tx_data <= w_first_byte;
                r_csum    <= r_csum ^ w_first_byte;
            end else if (i_next_byte) begin
                r_idx     <= w_next_idx;
                r_tx_data <= w_next_byte;
                r_csum    <= r_csum ^ w_next_byte;
            end else if (i_load_csum) begin
                r_tx_data <= r_csum;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word    <= '0;
            r_idx     <= '0;
            r_tx_data <= '0;
        end else begin
            if (i_capture) begin
                r_word    <= i_read_data;
                r_idx     <= '0;
                r_tx_data <= w_first_byte;
            end else if (i_next_byte) begin
                r_idx     <= w_next_idx;
                r_tx_data <= w_next_byte;
            end
        end
    end
`endif

endmodule

// File: rtl/register_dump_reader.sv
// Walks every bank register and streams its bytes to the debug UART transmitter.
// Define REG_DUMP_CHECKSUM_EN to append one XOR checksum byte after the last register.
//
// state   | meaning
// IDLE    | waiting for start
// CAPTURE | bank read settled, latch word for dir_read
// SEND    | tx_start high, byte presented
// WAIT    | hold byte until tx_done
// NEXT    | advance address or end the walk
// CSUM    | checksum byte presented (checksum build only)
// FINISH  | done pulse, address back to 0
module register_dump_reader
    import debug_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int BYTE_W   = BYTE_W_DEF
) (
    input  logic clk,
    input  logic rst,
    register_dump_reader_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    dump_state_t       r_state;
    logic [ADDR_W-1:0] r_dir_read;
    logic              r_tx_start;
    logic              r_busy;
    logic              r_done;

    logic              w_capture;
    logic              w_next_byte;
    logic              w_last_byte;
    logic              w_last_addr;

    assign w_last_addr = (r_dir_read == LAST_ADDR);
    assign w_capture   = (r_state == ST_CAPTURE);

`ifdef REG_DUMP_CHECKSUM_EN
    logic r_csum_phase;
    logic w_clear;
    logic w_load_csum;

    assign w_clear     = (r_state == ST_IDLE) && bus.start;
    assign w_load_csum = (r_state == ST_NEXT) && w_last_addr;
    assign w_next_byte = (r_state == ST_WAIT) && bus.tx_done && !w_last_byte && !r_csum_phase;
`else
    assign w_next_byte = (r_state == ST_WAIT) && bus.tx_done && !w_last_byte;
`endif

    word_serializer #(
        .DATA_W (DATA_W),
        .BYTE_W (BYTE_W)
    ) u_word_serializer (
        .clk         (clk),
        .rst         (rst),
        .i_capture   (w_capture),
        .i_next_byte (w_next_byte),
        .i_read_data (bus.read_data),
`ifdef REG_DUMP_CHECKSUM_EN
        .i_clear     (w_clear),
        .i_load_csum (w_load_csum),
`endif
        .o_tx_data   (bus.tx_data),
        .o_last_byte (w_last_byte)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_dir_read   <= '0;
            r_tx_start   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            r_csum_phase <= 1'b0;
`endif
        end else begin
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_dir_read <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_CAPTURE;
                    end
                end
                // tx_start is raised on entry so it coincides with the SEND cycle.
                ST_CAPTURE: begin
                    r_tx_start <= 1'b1;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.tx_done) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        if (r_csum_phase) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_FINISH;
                        end else
`endif
                        if (!w_last_byte) begin
                            r_tx_start <= 1'b1;
                            r_state    <= ST_SEND;
                        end else begin
                            r_state <= ST_NEXT;
                        end
                    end
                end
                ST_NEXT: begin
                    if (w_last_addr) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        r_tx_start   <= 1'b1;
                        r_csum_phase <= 1'b1;
                        r_state      <= ST_CSUM;
`else
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_FINISH;
`endif
                    end else begin
                        r_dir_read <= r_dir_read + 1'b1;
                        r_state    <= ST_CAPTURE;
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                ST_CSUM: begin
                    r_state <= ST_WAIT;
                end
`endif
                ST_FINISH: begin
                    r_dir_read   <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
                    r_csum_phase <= 1'b0;
`endif
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.dir_read = r_dir_read;
    assign bus.tx_start = r_tx_start;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule
